fetch_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 80 ++++++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Types, opcode constants and decode helpers shared by the pipeline stages.
// needs_imm() is the single definition of the immediate-bearing opcode set.
package pipeline_pkg;

    localparam logic [4:0] OP_IADD = 5'h0C;
    localparam logic [4:0] OP_LDM  = 5'h12;
    localparam logic [4:0] OP_LDD  = 5'h13;
    localparam logic [4:0] OP_STD  = 5'h14;

    typedef enum logic {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } fetch_state_t;

    function automatic logic needs_imm(input logic [4:0] opcode);
        return (opcode == OP_IADD) || (opcode == OP_LDM) ||
               (opcode == OP_LDD)  || (opcode == OP_STD);
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load on write, hold on stall, flush clears the payload.
// Handshake: flush beats stall beats load; pc fields survive a flush.
module ifid_reg #(
    parameter int                   W        = 16,
    parameter int                   PW       = 32,
    parameter logic [PW-1:0]        RESET_PC = PW'(32)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          load,
    input  logic [W-1:0]  in_inst,
    input  logic [W-1:0]  in_imm,
    input  logic          in_has_imm,
    input  logic [PW-1:0] in_pc,
    input  logic [PW-1:0] in_pc_next,
    output logic          out_valid,
    output logic [W-1:0]  out_inst,
    output logic [W-1:0]  out_imm,
    output logic          out_has_imm,
    output logic [PW-1:0] out_pc,
    output logic [PW-1:0] out_pc_next
);

    logic          valid_d,   valid_q;
    logic [W-1:0]  inst_d,    inst_q;
    logic [W-1:0]  imm_d,     imm_q;
    logic          has_imm_d, has_imm_q;
    logic [PW-1:0] pc_d,      pc_q;
    logic [PW-1:0] pc_next_d, pc_next_q;

    always_comb begin
        valid_d   = valid_q;
        inst_d    = inst_q;
        imm_d     = imm_q;
        has_imm_d = has_imm_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        if (flush) begin
            valid_d   = 1'b0;
            inst_d    = '0;
            imm_d     = '0;
            has_imm_d = 1'b0;
        end else if (!stall && load) begin
            valid_d   = 1'b1;
            inst_d    = in_inst;
            imm_d     = in_imm;
            has_imm_d = in_has_imm;
            pc_d      = in_pc;
            pc_next_d = in_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            inst_q    <= '0;
            imm_q     <= '0;
            has_imm_q <= 1'b0;
            pc_q      <= RESET_PC;
            pc_next_q <= RESET_PC;
        end else begin
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            imm_q     <= imm_d;
            has_imm_q <= has_imm_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_imm     = imm_q;
    assign out_has_imm = has_imm_q;
    assign out_pc      = pc_q;
    assign out_pc_next = pc_next_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, two-state opcode/immediate FSM and held-instruction register.
// Feeds the IF/ID register; dbg_state exposes the FSM for checkers.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                   Num_of_bits   = 16,
    parameter int                   pc_width      = 32,
    parameter int                   op_code_width = 5,
    parameter logic [pc_width-1:0]  RESET_PC      = pc_width'(32)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [pc_width-1:0]    redirect_pc,
    output logic [pc_width-1:0]    imem_addr,
    input  logic [Num_of_bits-1:0] imem_data,
    output logic                   ifid_valid,
    output logic [Num_of_bits-1:0] ifid_inst,
    output logic [Num_of_bits-1:0] ifid_imm,
    output logic                   ifid_has_imm,
    output logic [pc_width-1:0]    ifid_pc,
    output logic [pc_width-1:0]    ifid_pc_next,
    output fetch_state_t           dbg_state
);

    fetch_state_t            state_d,     state_q;
    logic [pc_width-1:0]     pc_d,        pc_q;
    logic [Num_of_bits-1:0]  held_inst_d, held_inst_q;
    logic [pc_width-1:0]     held_pc_d,   held_pc_q;

    logic                    opcode_imm;
    logic [pc_width-1:0]     pc_inc;
    logic                    wr_flush;
    logic                    wr_load;
    logic [Num_of_bits-1:0]  wr_inst;
    logic [Num_of_bits-1:0]  wr_imm;
    logic                    wr_has_imm;
    logic [pc_width-1:0]     wr_pc;
    logic [pc_width-1:0]     wr_pc_next;

    assign opcode_imm = needs_imm(5'(imem_data[op_code_width-1:0]));
    assign pc_inc     = pc_q + pc_width'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        held_inst_d = held_inst_q;
        held_pc_d   = held_pc_q;
        wr_flush    = 1'b0;
        wr_load     = 1'b0;
        wr_inst     = '0;
        wr_imm      = '0;
        wr_has_imm  = 1'b0;
        wr_pc       = pc_q;
        wr_pc_next  = pc_inc;
        if (redirect) begin
            pc_d        = redirect_pc;
            state_d     = FETCH_OP;
            held_inst_d = '0;
            wr_flush    = 1'b1;
        end else if (!stall) begin
            pc_d = pc_inc;
            case (state_q)
                FETCH_OP: begin
                    if (opcode_imm) begin
                        // Park the opcode word; IF/ID shows a bubble until the immediate arrives.
                        held_inst_d = imem_data;
                        held_pc_d   = pc_q;
                        state_d     = FETCH_IMM;
                        wr_flush    = 1'b1;
                    end else begin
                        wr_load = 1'b1;
                        wr_inst = imem_data;
                    end
                end
                FETCH_IMM: begin
                    wr_load    = 1'b1;
                    wr_inst    = held_inst_q;
                    wr_imm     = imem_data;
                    wr_has_imm = 1'b1;
                    wr_pc      = held_pc_q;
                    state_d    = FETCH_OP;
                end
                default: state_d = FETCH_OP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FETCH_OP;
            pc_q        <= RESET_PC;
            held_inst_q <= '0;
            held_pc_q   <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            held_inst_q <= held_inst_d;
            held_pc_q   <= held_pc_d;
        end
    end

    ifid_reg #(
        .W        (Num_of_bits),
        .PW       (pc_width),
        .RESET_PC (RESET_PC)
    ) u_ifid_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (wr_flush),
        .load        (wr_load),
        .in_inst     (wr_inst),
        .in_imm      (wr_imm),
        .in_has_imm  (wr_has_imm),
        .in_pc       (wr_pc),
        .in_pc_next  (wr_pc_next),
        .out_valid   (ifid_valid),
        .out_inst    (ifid_inst),
        .out_imm     (ifid_imm),
        .out_has_imm (ifid_has_imm),
        .out_pc      (ifid_pc),
        .out_pc_next (ifid_pc_next)
    );

    assign imem_addr = pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against an instruction-stream model
// built by walking the memory image (opcode words plus trailing immediates).
module tb_fetch_stage;
    import pipeline_pkg::*;

    localparam int EW = 98;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        ifid_valid;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_imm;
    logic        ifid_has_imm;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_next;
    fetch_state_t dbg_state;

    logic [15:0] mem [256];
    logic [EW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb imem_data = mem[imem_addr[7:0]];

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ifid_valid   (ifid_valid),
        .ifid_inst    (ifid_inst),
        .ifid_imm     (ifid_imm),
        .ifid_has_imm (ifid_has_imm),
        .ifid_pc      (ifid_pc),
        .ifid_pc_next (ifid_pc_next),
        .dbg_state    (dbg_state)
    );

    function automatic logic is_imm_op(input logic [15:0] w);
        logic [4:0] op;
        op = w[4:0];
        return op == 5'h0C || op == 5'h12 || op == 5'h13 || op == 5'h14;
    endfunction

    function automatic logic [EW-1:0] obs_pack();
        return {ifid_valid, ifid_inst, ifid_imm, ifid_has_imm, ifid_pc, ifid_pc_next};
    endfunction

    function automatic logic [EW-1:0] mk(input logic [15:0] inst, input logic [15:0] imm,
                                         input logic has, input logic [31:0] pc,
                                         input logic [31:0] pcn);
        return {1'b1, inst, imm, has, pc, pcn};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic with_stall);
        redirect    = 1'b1;
        redirect_pc = target;
        stall       = with_stall;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
    endtask

    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] last_exp;
        logic [31:0]   a;
        logic [15:0]   w;
        logic          s;
        int            free_edges;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
        mem[32] = 16'h1001; mem[33] = 16'h2002; mem[34] = 16'h3003; mem[35] = 16'h4004;
        mem[40] = 16'h0012; mem[41] = 16'hBEEF; mem[42] = 16'h0101; mem[43] = 16'h0013;
        mem[44] = 16'h7777;
        mem[100] = 16'h0205; mem[101] = 16'h0306; mem[102] = 16'h0407; mem[103] = 16'h0508;
        mem[255] = 16'h0003;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (2) step();
        chk("reset_addr",  128'(imem_addr), 128'(32));
        chk("reset_valid", 128'(ifid_valid), 128'(0));
        chk("reset_ifid",  128'(obs_pack()), 128'({1'b0, 16'h0, 16'h0, 1'b0, 32'd32, 32'd32}));
        chk("reset_state", 128'(dbg_state), 128'(FETCH_OP));
        rst_n = 1'b1;

        // Straight-line, no immediates.
        for (int i = 0; i < 4; i++) begin
            step();
            a = 32 + i;
            chk("straight", 128'(obs_pack()), 128'(mk(mem[a[7:0]], 16'h0, 1'b0, a, a + 1)));
        end
        chk("straight_addr", 128'(imem_addr), 128'(36));

        // Immediate instruction: LDM at 40 with 0xBEEF, ADD at 42.
        do_redirect(32'd40, 1'b0);
        chk("redir40_valid", 128'(ifid_valid), 128'(0));
        chk("redir40_addr",  128'(imem_addr), 128'(40));
        step();
        chk("ldm_bubble", 128'(ifid_valid), 128'(0));
        chk("ldm_state",  128'(dbg_state), 128'(FETCH_IMM));
        step();
        chk("ldm_full", 128'(obs_pack()), 128'(mk(16'h0012, 16'hBEEF, 1'b1, 32'd40, 32'd42)));
        step();
        chk("add_after", 128'(obs_pack()), 128'(mk(16'h0101, 16'h0, 1'b0, 32'd42, 32'd43)));

        // LDD at 43 fetched, then redirect+stall while in FETCH_IMM.
        step();
        chk("ldd_bubble", 128'(ifid_valid), 128'(0));
        do_redirect(32'd100, 1'b1);
        chk("redir_imm_ifid", 128'(obs_pack()), 128'({1'b0, 16'h0, 16'h0, 1'b0, 64'h0} & {1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 64'h0}) | 128'({ifid_pc, ifid_pc_next}));
        chk("redir_imm_addr",  128'(imem_addr), 128'(100));
        chk("redir_imm_state", 128'(dbg_state), 128'(FETCH_OP));
        step();
        chk("after_redir", 128'(obs_pack()), 128'(mk(16'h0205, 16'h0, 1'b0, 32'd100, 32'd101)));

        // Stall three cycles mid-stream.
        step();
        chk("pre_stall", 128'(obs_pack()), 128'(mk(16'h0306, 16'h0, 1'b0, 32'd101, 32'd102)));
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ifid", 128'(obs_pack()), 128'(mk(16'h0306, 16'h0, 1'b0, 32'd101, 32'd102)));
            chk("stall_addr", 128'(imem_addr), 128'(102));
        end
        stall = 1'b0;
        step();
        chk("post_stall0", 128'(obs_pack()), 128'(mk(16'h0407, 16'h0, 1'b0, 32'd102, 32'd103)));
        step();
        chk("post_stall1", 128'(obs_pack()), 128'(mk(16'h0508, 16'h0, 1'b0, 32'd103, 32'd104)));

        // PC wrap at all-ones.
        do_redirect(32'hFFFF_FFFF, 1'b0);
        chk("wrap_addr0", 128'(imem_addr), 128'(32'hFFFF_FFFF));
        step();
        chk("wrap_ifid", 128'(obs_pack()), 128'(mk(16'h0003, 16'h0, 1'b0, 32'hFFFF_FFFF, 32'h0)));
        chk("wrap_addr1", 128'(imem_addr), 128'(0));

        // Randomized stream with random stalls.
        for (int i = 128; i < 251; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0: w[4:0] = 5'h0C;
                    1: w[4:0] = 5'h12;
                    2: w[4:0] = 5'h13;
                    default: w[4:0] = 5'h14;
                endcase
            end
            mem[i] = w;
        end
        a = 32'd128;
        while (exp_q.size() < 90) begin
            w = mem[a[7:0]];
            if (is_imm_op(w)) begin
                exp_q.push_back('0);
                exp_q.push_back(mk(w, mem[8'(a + 1)], 1'b1, a, a + 2));
                a = a + 2;
            end else begin
                exp_q.push_back(mk(w, 16'h0, 1'b0, a, a + 1));
                a = a + 1;
            end
        end

        do_redirect(32'd128, 1'b0);
        last_exp   = '0;
        free_edges = 0;
        for (int i = 0; i < 80; i++) begin
            s = ($urandom_range(0, 3) == 0);
            stall = s;
            step();
            if (!s) begin
                free_edges++;
                e = exp_q.pop_front();
                last_exp = e;
            end
            if (last_exp[EW-1])
                chk(s ? "rand_stall_ifid" : "rand_ifid", 128'(obs_pack()), 128'(last_exp));
            else
                chk(s ? "rand_stall_bubble" : "rand_bubble", 128'(ifid_valid), 128'(0));
            chk("rand_addr", 128'(imem_addr), 128'(32'd128 + 32'(free_edges)));
        end
        stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
